// File: rtl/dds_multimode_modulator.sv
// Direct digital synthesiser with ASK / FSK / BPSK symbol modulation.
// Phase accumulator -> sine LUT -> modulator. The symbol bit and mode travel with each sample.
module dds_multimode_modulator #(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16,
    parameter int SYM_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [ACC_W-1:0]        increment0,
    input  logic [ACC_W-1:0]        increment1,
    input  logic [LUT_AW-1:0]       phase,
    input  logic [SYM_W-1:0]        sym_period,
    input  logic                    data_valid,
    input  logic                    data,
    output logic                    data_ready,
    output logic signed [OUT_W-1:0] sine,
    output logic signed [OUT_W-1:0] mod_out,
    output logic                    sym_strobe,
    output logic                    underrun
);
    localparam int LUT_N = 1 << LUT_AW;
    localparam logic [1:0] MODE_ASK  = 2'b00;
    localparam logic [1:0] MODE_FSK  = 2'b01;
    localparam logic [1:0] MODE_BPSK = 2'b10;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic signed [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] sine_entry(input int k);
        real amp;
        real x;
        amp = real'((longint'(1) << (OUT_W - 1)) - 1);
        x = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N));
        if (x >= 0.0)
            return OUT_W'($rtoi(x + 0.5));
        return OUT_W'(-$rtoi(0.5 - x));
    endfunction

    function automatic logic signed [OUT_W-1:0] neg_sat(input logic signed [OUT_W-1:0] x);
        return (x == MIN_NEG) ? MAX_POS : -x;
    endfunction

    function automatic logic signed [OUT_W-1:0] modulate(
        input logic signed [OUT_W-1:0] s,
        input logic                    v,
        input logic                    b,
        input logic [1:0]              m
    );
        logic signed [OUT_W-1:0] r;
        r = '0;
        if (v) begin
            case (m)
                MODE_ASK:  r = b ? s : '0;
                MODE_FSK:  r = s;
                MODE_BPSK: r = b ? neg_sat(s) : s;
                default:   r = '0;
            endcase
        end
        return r;
    endfunction

    logic signed [OUT_W-1:0] lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = sine_entry(k);
    end

    logic [ACC_W-1:0]  acc_p0;
    logic [ACC_W-1:0]  inc;
    logic [LUT_AW-1:0] addr_p0;
    logic [0:0]        state;
    logic [SYM_W-1:0]  cnt;
    logic [SYM_W-1:0]  per_len;
    logic              cur_bit;
    logic [1:0]        cur_mode;
    logic              buf_full;
    logic              buf_bit;
    logic              take;
    logic              sym_end;
    logic              load;
    logic              vld_p1;
    logic              bit_p1;
    logic [1:0]        mode_p1;

    assign data_ready = !buf_full && !reset;
    assign take       = data_valid && data_ready;
    assign sym_end    = (state == RUN) && (cnt == per_len - SYM_W'(1));
    assign load       = buf_full && ((state == IDLE) || sym_end);
    assign inc        = ((state == RUN) && (cur_mode == MODE_FSK) && cur_bit) ? increment1 : increment0;
    assign addr_p0    = acc_p0[ACC_W-1 -: LUT_AW] + phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            buf_full   <= 1'b0;
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sym_strobe <= load;
            underrun   <= sym_end && !buf_full;
            if (take)
                buf_full <= 1'b1;
            else if (load)
                buf_full <= 1'b0;
            if (load) begin
                state <= RUN;
                cnt   <= '0;
            end else if (sym_end) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + SYM_W'(1);
            end
        end
    end

    // Symbol payload registers; meaningful only while the control flags say so.
    always_ff @(posedge clock) begin
        if (take)
            buf_bit <= data;
        if (load) begin
            cur_bit  <= buf_bit;
            cur_mode <= mode;
            per_len  <= (sym_period == '0) ? SYM_W'(1) : sym_period;
        end
        bit_p1  <= cur_bit;
        mode_p1 <= cur_mode;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_p0  <= '0;
            sine    <= '0;
            vld_p1  <= 1'b0;
            mod_out <= '0;
        end else begin
            acc_p0  <= acc_p0 + inc;
            // p0 -> p1: LUT lookup, symbol tag follows the sample
            sine    <= lut[addr_p0];
            vld_p1  <= (state == RUN);
            // p1 -> p2: modulation
            mod_out <= modulate(sine, vld_p1, bit_p1, mode_p1);
        end
    end
endmodule

// File: tb/tb_dds_multimode_modulator.sv
// Randomised and directed bench for dds_multimode_modulator against a behavioural model.
`timescale 1ns/1ps
module tb_dds_multimode_modulator;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [31:0] increment0 = 32'h0800_0000;
    logic [31:0] increment1 = 32'h1000_0000;
    logic [7:0]  phase = 8'd0;
    logic [15:0] sym_period = 16'd100;
    logic        data_valid = 1'b0;
    logic        data = 1'b0;
    logic        data_ready;
    logic signed [15:0] sine;
    logic signed [15:0] mod_out;
    logic        sym_strobe;
    logic        underrun;

    dds_multimode_modulator #(.ACC_W(32), .LUT_AW(8), .OUT_W(16), .SYM_W(16)) dut (
        .clock(clock), .reset(reset), .mode(mode), .increment0(increment0),
        .increment1(increment1), .phase(phase), .sym_period(sym_period),
        .data_valid(data_valid), .data(data), .data_ready(data_ready),
        .sine(sine), .mod_out(mod_out), .sym_strobe(sym_strobe), .underrun(underrun)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // model state
    longint m_acc = 0;
    int  m_sine = 0, m_mod = 0;
    bit  m_strobe = 0, m_under = 0;
    bit  m_active = 0, m_bit = 0;
    int  m_mode = 0, m_left = 0;
    bit  t_active = 0, t_bit = 0;
    int  t_mode = 0;
    int  fifo[$];
    int  tx_q[$];
    bit  offer_en = 1;

    // window statistics
    int cyc = 0;
    int n_strobe, n_under, first_strobe, last_strobe, last_under, n_mod_nz, n_min;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lut_model(input int k);
        real x;
        x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int mod_model(input int s, input bit act, input bit b, input int md);
        int r;
        if (!act) return 0;
        case (md)
            0: r = b ? s : 0;
            1: r = s;
            2: begin
                r = b ? -s : s;
                if (r > 32767) r = 32767;
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic clear_stats();
        n_strobe = 0; n_under = 0; first_strobe = -1; last_strobe = -1;
        last_under = -1; n_mod_nz = 0; n_min = 0;
    endtask

    task automatic tick();
        bit rdy, xfer;
        longint inc, n_acc;
        int n_sine, n_mod;
        bit n_strobe_m, n_under_m;
        data_valid = offer_en && (tx_q.size() != 0);
        data = (tx_q.size() != 0) ? tx_q[0][0] : 1'b0;
        #1;
        rdy = !reset && (fifo.size() == 0);
        chk("data_ready", data_ready, rdy);
        xfer = data_valid && rdy;
        if (reset) begin
            n_acc = 0; n_sine = 0; n_mod = 0; n_strobe_m = 0; n_under_m = 0;
            m_active = 0; m_left = 0; t_active = 0;
            fifo.delete();
        end else begin
            inc = (m_active && m_mode == 1 && m_bit) ? longint'(increment1) : longint'(increment0);
            n_acc = (m_acc + inc) & 64'hFFFF_FFFF;
            n_sine = lut_model(int'(((m_acc >> 24) + longint'(phase)) & 255));
            n_mod = mod_model(m_sine, t_active, t_bit, t_mode);
            t_active = m_active; t_bit = m_bit; t_mode = m_mode;
            n_strobe_m = 0; n_under_m = 0;
            if (m_active && m_left > 1) begin
                m_left--;
            end else if (fifo.size() != 0) begin
                m_bit = fifo.pop_front() != 0;
                m_mode = int'(mode);
                m_left = (sym_period == 0) ? 1 : int'(sym_period);
                m_active = 1;
                n_strobe_m = 1;
            end else if (m_active) begin
                m_active = 0;
                n_under_m = 1;
            end
            if (xfer) fifo.push_back(int'(data));
        end
        if (xfer) void'(tx_q.pop_front());
        @(posedge clock);
        #1;
        cyc++;
        m_acc = n_acc; m_sine = n_sine; m_mod = n_mod; m_strobe = n_strobe_m; m_under = n_under_m;
        chk("sine", sine, m_sine);
        chk("mod_out", mod_out, m_mod);
        chk("sym_strobe", sym_strobe, m_strobe);
        chk("underrun", underrun, m_under);
        if (mod_out != 0) n_mod_nz++;
        if (mod_out == -16'sd32768) n_min++;
        if (sym_strobe) begin
            n_strobe++;
            if (first_strobe < 0) first_strobe = cyc;
            last_strobe = cyc;
        end
        if (underrun) begin
            n_under++;
            last_under = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int s_first;
        clear_stats();
        // model pins
        chk("lut0", lut_model(0), 0);
        chk("lut32", lut_model(32), 23170);
        chk("lut64", lut_model(64), 32767);
        chk("lut192", lut_model(192), -32767);
        chk("bpsk_neg", mod_model(1234, 1, 1, 2), -1234);
        chk("ask_zero", mod_model(1234, 1, 0, 0), 0);

        // reset and idle carrier
        reset = 1'b1;
        run(3);
        chk("rst_sine", sine, 0);
        chk("rst_mod", mod_out, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", data_ready, 1);
        clear_stats();
        tick();
        chk("idle_sine_first", sine, 0);
        run(8);
        chk("idle_sine_peak", sine, 32767);
        run(32);
        chk("idle_sine_period", sine, 32767);
        chk("idle_mod_zero", n_mod_nz, 0);

        // ASK 1,1,0,0 at 100 clocks per symbol
        mode = 2'b00; sym_period = 16'd100;
        clear_stats();
        tx_q = '{1, 1, 0, 0};
        run(430);
        chk("ask_strobes", n_strobe, 4);
        chk("ask_strobe_span", last_strobe - first_strobe, 300);
        chk("ask_underruns", n_under, 1);
        chk("ask_underrun_pos", last_under - last_strobe, 100);

        // BPSK 0,1
        mode = 2'b10; sym_period = 16'd40;
        clear_stats();
        tx_q = '{0, 1};
        run(100);
        chk("bpsk_strobes", n_strobe, 2);
        chk("bpsk_no_min", n_min, 0);

        // FSK 0,1 with phase-continuous increment change
        mode = 2'b01; sym_period = 16'd64;
        increment0 = 32'h0800_0000; increment1 = 32'h1000_0000;
        clear_stats();
        tx_q = '{0, 1};
        run(140);
        chk("fsk_strobes", n_strobe, 2);

        // single one-cycle symbol
        mode = 2'b00; sym_period = 16'd0;
        clear_stats();
        tx_q = '{1};
        run(10);
        chk("p0_strobes", n_strobe, 1);
        chk("p0_underruns", n_under, 1);
        chk("p0_gap", last_under - last_strobe, 1);

        // reset in the middle of a symbol with a bit buffered
        sym_period = 16'd100;
        clear_stats();
        tx_q = '{1, 1};
        s_first = 0;
        while (n_strobe == 0 && s_first < 10) begin
            tick();
            s_first++;
        end
        chk("mid_rst_started", n_strobe, 1);
        run(49);
        reset = 1'b1;
        tick();
        chk("mid_rst_sine", sine, 0);
        chk("mid_rst_mod", mod_out, 0);
        chk("mid_rst_under", underrun, 0);
        reset = 1'b0;
        tx_q.delete();
        clear_stats();
        run(150);
        chk("post_rst_mod_nz", n_mod_nz, 0);
        chk("post_rst_strobes", n_strobe, 0);
        chk("post_rst_underruns", n_under, 0);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) sym_period = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) phase = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                increment0 = $urandom;
                increment1 = $urandom;
            end
            reset = ($urandom_range(0, 499) == 0);
            offer_en = ($urandom_range(0, 3) != 0);
            if (reset) tx_q.delete();
            else if (tx_q.size() == 0) tx_q.push_back(int'($urandom_range(0, 1)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dds_multimode_modulator.md
DDS_MULTIMODE_MODULATOR -- requirements
Module: dds_multimode_modulator

Interface
REQ-001 Parameter ACC_W, default 32: phase accumulator and increment width.
REQ-002 Parameter LUT_AW, default 8: sine LUT address width, 2^LUT_AW entries per period.
REQ-003 Parameter OUT_W, default 16: signed sample width.
REQ-004 Parameter SYM_W, default 16: symbol period counter width.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 mode  in  2  00 ASK, 01 FSK, 10 BPSK, 11 carrier-off (mod_out held 0).
REQ-008 increment0  in  ACC_W  carrier increment; FSK space (bit 0).
REQ-009 increment1  in  ACC_W  FSK mark increment (bit 1); ignored in other modes.
REQ-010 phase  in  LUT_AW  phase offset added to the LUT address.
REQ-011 sym_period  in  SYM_W  clocks per symbol; 0 treated as 1.
REQ-012 data_valid / data  in  1 / 1  symbol bit offer.
REQ-013 data_ready  out  1  block can accept a bit this cycle.
REQ-014 sine  out  OUT_W  signed unmodulated carrier sample.
REQ-015 mod_out  out  OUT_W  signed modulated sample.
REQ-016 sym_strobe  out  1  one-cycle pulse when a new symbol starts.
REQ-017 underrun  out  1  one-cycle pulse when a symbol ends with no next bit buffered.

Function
REQ-018 Accumulator: acc <= acc + inc every cycle, wrapping mod 2^ACC_W; inc = increment1 when mode=FSK and current bit=1, else increment0.
REQ-019 LUT address = acc[ACC_W-1 -: LUT_AW] + phase, mod 2^LUT_AW.
REQ-020 LUT entry k = round((2^(OUT_W-1)-1)*sin(2*pi*k/2^LUT_AW)); entry 0 = 0, entry 2^LUT_AW/4 = max positive.
REQ-021 sine is registered one cycle after the acc value that addresses it.
REQ-022 mod_out is registered one cycle after sine; the symbol bit and mode are pipelined with the sample, so symbol boundaries on mod_out are sample-exact.
REQ-023 Symbol states: IDLE (no current bit), RUN (current bit held for sym_period cycles).
REQ-024 One-entry next-bit buffer; data_ready = !buffer_full; a transfer occurs when data_valid & data_ready.
REQ-025 IDLE with buffer full: next cycle load current bit, clear buffer, enter RUN, pulse sym_strobe, counter = 0.
REQ-026 RUN: counter increments; at counter = sym_period-1, if buffer full, reload as in REQ-025 (back-to-back, no gap); else pulse underrun and enter IDLE.
REQ-027 A transfer in the same cycle that the buffer is drained at a boundary is not possible, since data_ready=0 while full; the buffer refills from the cycle after drain.
REQ-028 mode and sym_period are sampled at symbol start and held for that symbol; mode is applied directly in IDLE.
REQ-029 ASK: bit 1 gives sine, bit 0 gives 0.
REQ-030 FSK: sample = sine; phase-continuous across increment changes (acc is never reset).
REQ-031 BPSK: bit 0 gives sine, bit 1 gives -sine, saturated to the max positive value.
REQ-032 In IDLE or mode 11, mod_out = 0; the accumulator and sine keep running.

Reset
REQ-033 While reset=1: acc=0, sine=0, mod_out=0, sym_strobe=0, underrun=0, data_ready=0, state IDLE, buffer empty, counter=0.
REQ-034 data_ready=1 in the first cycle after reset deasserts.
REQ-035 Reset mid-symbol discards the current and buffered bits; no underrun pulse is generated.

Verification
REQ-036 Defaults, increment0=0x08000000, phase=0, no data -> sine period 32 clocks; sine=0 then 32767 eight samples later; mod_out stays 0; data_ready=1.
REQ-037 ASK, sym_period=100, bits 1,1,0,0 streamed -> mod_out=sine for 200 samples, then 0 for 200 samples; sym_strobe every 100 cycles; underrun once at the end.
REQ-038 BPSK, bits 0,1 -> second symbol mod_out = -sine exactly; no sample equals -32768.
REQ-039 FSK, increment0=0x08000000, increment1=0x10000000, bits 0,1 -> period 32 then 16; LUT address continuous at the boundary with no phase jump.
REQ-040 sym_period=0 with one bit -> symbol lasts 1 cycle; sym_strobe then underrun on consecutive cycles.
REQ-041 Reset asserted at cycle 50 of a 100-cycle symbol with a bit buffered -> all outputs 0 the next cycle; no mod_out activity after release until new data arrives.
